render_cmd_sender: RTL and testbench

//  Host-side transmitter for the render command byte interface. Accepts one

---
 rtl/render_cmd_sender.sv | 184 ++++++++++++++++++
 tb/tb_render_cmd_sender.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_cmd_sender.sv
// Host-side render command transmitter: serialises one packed draw command on
// TByte/VALID under STATUS, then waits for the receiver's read/write completion.
module render_cmd_sender #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int LEAD_CYCLES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic        ACLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [55:0] CMD_DATA,
  output logic        STATUS,
  output logic [7:0]  TByte,
  output logic        VALID,
  input  logic        FinishRead,
  input  logic        FinishWrite,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  generate
    if (HOLD_CYCLES < 3) begin : g_bad_hold
      $error("render_cmd_sender: HOLD_CYCLES must be >= 3");
    end
    if (GAP_CYCLES < 2) begin : g_bad_gap
      $error("render_cmd_sender: GAP_CYCLES must be >= 2");
    end
    if (LEAD_CYCLES < 1) begin : g_bad_lead
      $error("render_cmd_sender: LEAD_CYCLES must be >= 1");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("render_cmd_sender: TIMEOUT must be in 1..65535");
    end
  endgenerate

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEAD    = 3'd1;
  localparam logic [2:0] S_DRIVE   = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_WAIT_RD = 3'd4;
  localparam logic [2:0] S_WAIT_WR = 3'd5;

  localparam logic [15:0] LEAD_LAST = 16'(LEAD_CYCLES - 1);
  localparam logic [15:0] HOLD_END  = 16'(HOLD_CYCLES);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 2);
  localparam logic [15:0] TIME_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [55:0] shadow;
  logic [2:0]  k;
  logic [15:0] cnt;
  logic [15:0] timer;
  logic        fr_q;
  logic        fw_q;
  logic        hs;
  logic        fr_rise;
  logic        fw_rise;
  logic [2:0]  k_last;

  // Byte 7 lies beyond CMD_DATA and reads as zero.
  function automatic logic [7:0] cmd_byte(input logic [55:0] d, input logic [2:0] idx);
    logic [63:0] ext;
    ext = {8'h00, d};
    return ext[{idx, 3'b000} +: 8];
  endfunction

  assign CMD_READY = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);
  assign hs        = CMD_VALID & CMD_READY;
  assign fr_rise   = FinishRead & ~fr_q;
  assign fw_rise   = FinishWrite & ~fw_q;
  assign k_last    = {shadow[1:0], 1'b1};

  // DRIVE spends its first cycle settling TByte before VALID rises, so that
  // cycle counts toward the low gap and GAP itself lasts GAP_CYCLES-1 cycles.
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      shadow <= '0;
      k      <= '0;
      cnt    <= '0;
      timer  <= '0;
      fr_q   <= 1'b0;
      fw_q   <= 1'b0;
      STATUS <= 1'b0;
      VALID  <= 1'b0;
      TByte  <= '0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      fr_q <= FinishRead;
      fw_q <= FinishWrite;
      case (state)
        S_IDLE: begin
          if (hs) begin
            shadow <= CMD_DATA;
            if (CMD_DATA[7:0] == 8'h00) begin
              ERR <= 1'b1;
            end else begin
              state  <= S_LEAD;
              STATUS <= 1'b1;
              k      <= '0;
              cnt    <= '0;
            end
          end
        end
        S_LEAD: begin
          if (cnt == LEAD_LAST) begin
            state <= S_DRIVE;
            TByte <= cmd_byte(shadow, k);
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DRIVE: begin
          if (cnt == 16'd0) begin
            VALID <= 1'b1;
          end
          if (cnt == HOLD_END) begin
            VALID <= 1'b0;
            state <= S_GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (k == k_last) begin
              state <= S_WAIT_RD;
              timer <= '0;
            end else begin
              k     <= k + 3'd1;
              TByte <= cmd_byte(shadow, k + 3'd1);
              state <= S_DRIVE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WAIT_RD: begin
          if (fr_rise) begin
            state  <= S_WAIT_WR;
            STATUS <= 1'b0;
            timer  <= '0;
          end else if (timer == TIME_LAST) begin
            ERR    <= 1'b1;
            STATUS <= 1'b0;
            VALID  <= 1'b0;
            state  <= S_IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_WAIT_WR: begin
          if (fw_rise) begin
            DONE  <= 1'b1;
            state <= S_IDLE;
          end else if (timer == TIME_LAST) begin
            ERR    <= 1'b1;
            STATUS <= 1'b0;
            VALID  <= 1'b0;
            state  <= S_IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          STATUS <= 1'b0;
          VALID  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_render_cmd_sender.sv
// Directed bench for render_cmd_sender: byte framing, completion handshake,
// zero opcode, timeouts, mid-transfer reset and stale FinishWrite.
module tb_render_cmd_sender;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int LEAD = 2;
  localparam int TMO  = 100;

  logic        ACLK;
  logic        RESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [55:0] CMD_DATA;
  logic        STATUS;
  logic [7:0]  TByte;
  logic        VALID;
  logic        FinishRead;
  logic        FinishWrite;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_byte [8];
  int         rx_hi   [8];
  int         rx_lo   [8];

  render_cmd_sender #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .LEAD_CYCLES(LEAD),
    .TIMEOUT    (TMO)
  ) dut (
    .ACLK       (ACLK),
    .RESET      (RESET),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_DATA   (CMD_DATA),
    .STATUS     (STATUS),
    .TByte      (TByte),
    .VALID      (VALID),
    .FinishRead (FinishRead),
    .FinishWrite(FinishWrite),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_cmd(input logic [55:0] d);
    CMD_DATA  = d;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
  endtask

  // Receiver-side capture: byte k of the burst lands in rx_byte[k].
  task automatic collect(input int n, output int got);
    logic prev;
    int   budget;
    got = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      rx_byte[i] = 8'h00;
      rx_hi[i]   = 0;
      rx_lo[i]   = 0;
    end
    prev   = VALID;
    budget = 0;
    while (budget < 400) begin
      tick();
      budget++;
      if (VALID && !prev && got < 8) begin
        rx_byte[got] = TByte;
        got++;
      end
      if (VALID && got > 0) rx_hi[got-1]++;
      else if (!VALID && got > 0 && got < n) rx_lo[got-1]++;
      if (!VALID && prev && got == n) break;
      prev = VALID;
    end
  endtask

  task automatic test_reset();
    RESET       = 1'b1;
    CMD_VALID   = 1'b0;
    CMD_DATA    = '0;
    FinishRead  = 1'b0;
    FinishWrite = 1'b0;
    repeat (2) tick();
    tests++;
    if ({CMD_READY, STATUS, VALID, BUSY, DONE, ERR, TByte} !== {6'b100000, 8'h00}) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected %b",
               {CMD_READY, STATUS, VALID, BUSY, DONE, ERR, TByte}, {6'b100000, 8'h00});
    end
    RESET = 1'b0;
    tick();
    tests++;
    if ({CMD_READY, BUSY} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release: got ready/busy %b expected 10", {CMD_READY, BUSY});
    end
  endtask

  task automatic test_basic();
    int got;
    send_cmd(56'h07_0605_0403_0201);
    tests++;
    if ({BUSY, CMD_READY, STATUS} !== 3'b101) begin
      fails++;
      $display("FAIL basic_start: got busy/ready/status %b expected 101", {BUSY, CMD_READY, STATUS});
    end
    // a command offered while busy must be ignored
    CMD_DATA  = 56'hFF_FFFF_FFFF_FFFF;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
    collect(4, got);
    tests++;
    if (got !== 4) begin
      fails++;
      $display("FAIL basic_count: got %0d bytes expected 4", got);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      tests++;
      if (rx_byte[i] !== 8'(i + 1) || rx_hi[i] !== HOLD) begin
        fails++;
        $display("FAIL basic_byte%0d: got %h hi=%0d expected %h hi=%0d",
                 i, rx_byte[i], rx_hi[i], 8'(i + 1), HOLD);
      end
    end
    for (int unsigned i = 0; i < 3; i++) begin
      tests++;
      if (rx_lo[i] !== GAP) begin
        fails++;
        $display("FAIL basic_gap%0d: got %0d low cycles expected %0d", i, rx_lo[i], GAP);
      end
    end
    tick();
    tick();
    tests++;
    if (STATUS !== 1'b1) begin
      fails++;
      $display("FAIL basic_wait_rd_status: got %b expected 1", STATUS);
    end
    FinishRead = 1'b1;
    tick();
    tests++;
    if ({STATUS, BUSY, DONE} !== 3'b010) begin
      fails++;
      $display("FAIL basic_finish_read: got status/busy/done %b expected 010", {STATUS, BUSY, DONE});
    end
    FinishWrite = 1'b1;
    tick();
    tests++;
    if ({DONE, BUSY, CMD_READY, ERR} !== 4'b1010) begin
      fails++;
      $display("FAIL basic_done: got done/busy/ready/err %b expected 1010", {DONE, BUSY, CMD_READY, ERR});
    end
    tick();
    tests++;
    if (DONE !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse: got %b expected 0", DONE);
    end
    FinishRead = 1'b0;
    tick();
  endtask

  task automatic test_stale_finish_write();
    int   got;
    logic done_seen;
    send_cmd(56'h00_0000_4433_2211);
    collect(4, got);
    tests++;
    if (got !== 4 || rx_byte[0] !== 8'h11 || rx_byte[3] !== 8'h44) begin
      fails++;
      $display("FAIL stale_bytes: got n=%0d b0=%h b3=%h expected n=4 b0=11 b3=44",
               got, rx_byte[0], rx_byte[3]);
    end
    tick();
    tick();
    FinishRead = 1'b1;
    tick();
    tests++;
    if (STATUS !== 1'b0) begin
      fails++;
      $display("FAIL stale_status: got %b expected 0", STATUS);
    end
    done_seen = 1'b0;
    repeat (6) begin
      tick();
      done_seen |= DONE;
    end
    tests++;
    if ({done_seen, BUSY} !== 2'b01) begin
      fails++;
      $display("FAIL stale_no_done: got done_seen/busy %b expected 01", {done_seen, BUSY});
    end
    FinishWrite = 1'b0;
    tick();
    FinishWrite = 1'b1;
    tick();
    tests++;
    if ({DONE, BUSY} !== 2'b10) begin
      fails++;
      $display("FAIL stale_fresh_edge: got done/busy %b expected 10", {DONE, BUSY});
    end
    FinishRead  = 1'b0;
    FinishWrite = 1'b0;
    tick();
  endtask

  task automatic test_eight_bytes();
    int         got;
    logic [7:0] exp8 [8];
    exp8 = '{8'h03, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00};
    send_cmd(56'h77_6655_4433_2203);
    collect(8, got);
    tests++;
    if (got !== 8) begin
      fails++;
      $display("FAIL eight_count: got %0d bytes expected 8", got);
    end
    for (int unsigned i = 0; i < 8; i++) begin
      tests++;
      if (rx_byte[i] !== exp8[i]) begin
        fails++;
        $display("FAIL eight_reg%0d: got %h expected %h", i, rx_byte[i], exp8[i]);
      end
    end
    tick();
    tick();
    FinishRead = 1'b1;
    tick();
    FinishWrite = 1'b1;
    tick();
    tests++;
    if ({DONE, ERR, BUSY} !== 3'b100) begin
      fails++;
      $display("FAIL eight_done: got done/err/busy %b expected 100", {DONE, ERR, BUSY});
    end
    FinishRead  = 1'b0;
    FinishWrite = 1'b0;
    tick();
  endtask

  task automatic test_zero_opcode();
    logic activity;
    send_cmd(56'h11_2233_4455_6600);
    tests++;
    if ({ERR, STATUS, VALID, CMD_READY, BUSY} !== 5'b10010) begin
      fails++;
      $display("FAIL zero_err: got err/status/valid/ready/busy %b expected 10010",
               {ERR, STATUS, VALID, CMD_READY, BUSY});
    end
    activity = 1'b0;
    repeat (10) begin
      tick();
      activity |= STATUS | VALID | BUSY | ERR | ~CMD_READY;
    end
    tests++;
    if (activity !== 1'b0) begin
      fails++;
      $display("FAIL zero_quiet: got activity %b expected 0", activity);
    end
  endtask

  task automatic test_timeout();
    int   got;
    int   n;
    logic status_lost;
    send_cmd(56'h00_0000_0403_0201);
    collect(4, got);
    n = 0;
    status_lost = 1'b0;
    while (ERR !== 1'b1 && n < 300) begin
      tick();
      n++;
      if (ERR !== 1'b1 && STATUS !== 1'b1) status_lost = 1'b1;
    end
    tests++;
    if (n !== GAP - 1 + TMO) begin
      fails++;
      $display("FAIL timeout_cycle: got ERR after %0d cycles expected %0d", n, GAP - 1 + TMO);
    end
    tests++;
    if ({STATUS, VALID, BUSY, DONE, status_lost} !== 5'b00000) begin
      fails++;
      $display("FAIL timeout_state: got status/valid/busy/done/lost %b expected 00000",
               {STATUS, VALID, BUSY, DONE, status_lost});
    end
    tick();
    tests++;
    if ({ERR, CMD_READY} !== 2'b01) begin
      fails++;
      $display("FAIL timeout_idle: got err/ready %b expected 01", {ERR, CMD_READY});
    end
  endtask

  task automatic test_simultaneous_edges();
    int   got;
    int   n;
    logic done_seen;
    send_cmd(56'h00_0000_0403_0201);
    collect(4, got);
    tick();
    tick();
    FinishRead  = 1'b1;
    FinishWrite = 1'b1;
    tick();
    tests++;
    if ({STATUS, DONE, BUSY} !== 3'b001) begin
      fails++;
      $display("FAIL simul_wait_wr: got status/done/busy %b expected 001", {STATUS, DONE, BUSY});
    end
    n = 0;
    done_seen = 1'b0;
    while (ERR !== 1'b1 && n < 300) begin
      tick();
      n++;
      done_seen |= DONE;
    end
    tests++;
    if (n !== TMO || done_seen !== 1'b0) begin
      fails++;
      $display("FAIL simul_timeout: got %0d cycles done_seen=%b expected %0d, 0", n, done_seen, TMO);
    end
    FinishRead  = 1'b0;
    FinishWrite = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    int   got;
    int   n;
    int   rises;
    logic prev;
    logic pulse_seen;
    send_cmd(56'h07_0605_0403_0201);
    rises = 0;
    n     = 0;
    prev  = VALID;
    while (rises < 2 && n < 100) begin
      tick();
      n++;
      if (VALID && !prev) rises++;
      prev = VALID;
    end
    tests++;
    if (rises !== 2 || TByte !== 8'h02) begin
      fails++;
      $display("FAIL rst_reach_byte2: got rises=%0d byte=%h expected 2, 02", rises, TByte);
    end
    #2 RESET = 1'b1;
    #1;
    tests++;
    if ({VALID, STATUS, CMD_READY, BUSY, DONE, ERR} !== 6'b001000) begin
      fails++;
      $display("FAIL rst_async: got valid/status/ready/busy/done/err %b expected 001000",
               {VALID, STATUS, CMD_READY, BUSY, DONE, ERR});
    end
    pulse_seen = 1'b0;
    repeat (2) begin
      tick();
      pulse_seen |= DONE | ERR;
    end
    RESET = 1'b0;
    repeat (3) begin
      tick();
      pulse_seen |= DONE | ERR | BUSY;
    end
    tests++;
    if (pulse_seen !== 1'b0) begin
      fails++;
      $display("FAIL rst_no_pulse: got %b expected 0", pulse_seen);
    end
    send_cmd(56'h00_0000_99AA_BBC1);
    collect(4, got);
    tests++;
    if ({rx_byte[0], rx_byte[1], rx_byte[2], rx_byte[3]} !== 32'hC1BB_AA99 || got !== 4) begin
      fails++;
      $display("FAIL rst_new_bytes: got n=%0d %h%h%h%h expected n=4 C1BBAA99",
               got, rx_byte[0], rx_byte[1], rx_byte[2], rx_byte[3]);
    end
    tick();
    tick();
    FinishRead = 1'b1;
    tick();
    FinishWrite = 1'b1;
    tick();
    tests++;
    if ({DONE, ERR, BUSY} !== 3'b100) begin
      fails++;
      $display("FAIL rst_new_done: got done/err/busy %b expected 100", {DONE, ERR, BUSY});
    end
    FinishRead  = 1'b0;
    FinishWrite = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale_finish_write();
    test_eight_bytes();
    test_zero_opcode();
    test_timeout();
    test_simultaneous_edges();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
